// File: rtl/bcd_timer_ctrl.sv
// ============================================================================
// Module   : bcd_timer_ctrl
// Brief    : Run controller for a 2-digit cascaded BCD counter. It provides the
//            prescaled count tick, up/down mode, clear and stop-at-target control.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_timer_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int DIV_W    = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             dir_down_i,
    input  logic [7:0]       target_i,
    input  logic [3:0]       q0_i,
    input  logic [3:0]       q1_i,
    input  logic             tc_i,
    output logic             cnt_count_o,
    output logic             cnt_mode_o,
    output logic             cnt_rstn_o,
    output logic             running_o,
    output logic             done_o,
    output logic [1:0]       state_o,
    output logic             wrap_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] c_PRESC_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] c_PRESC_ONE  = DIV_W'(1);

    state_t            state_q;
    logic [DIV_W-1:0]  presc_q;
    logic [DIV_W-1:0]  presc_d;
    logic              cnt_count_q;
    logic              cnt_mode_q;
    logic              cnt_rstn_q;
    logic              running_q;
    logic              done_q;
    logic              wrap_q;

    logic              w_tick;
    logic              w_target_valid;
    logic              w_match;
    logic              w_go;

    // A target digit above 9 can never be shown by the counter, so it disables the stop.
    assign w_target_valid = (target_i[7:4] <= 4'd9) && (target_i[3:0] <= 4'd9);
    assign w_match        = w_target_valid && ({q1_i, q0_i} == target_i);
    assign w_go           = start_i && !stop_i;
    assign w_tick         = (presc_q == c_PRESC_LAST);

    always_comb begin
        presc_d = presc_q + c_PRESC_ONE;
        if (w_tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            cnt_count_q <= 1'b0;
            cnt_mode_q  <= 1'b0;
            cnt_rstn_q  <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            cnt_count_q <= 1'b0;
            cnt_rstn_q  <= ~clear_i;
            wrap_q      <= cnt_count_q & tc_i;
            if (clear_i) begin
                state_q   <= ST_IDLE;
                presc_q   <= '0;
                running_q <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_go) begin
                            state_q    <= ST_RUN;
                            cnt_mode_q <= dir_down_i;
                            presc_q    <= '0;
                            running_q  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Stop outranks the target match; the match outranks a tick.
                        if (stop_i) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end else if (w_match) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            presc_q     <= presc_d;
                            cnt_count_q <= w_tick;
                        end
                    end
                    ST_PAUSE: begin
                        if (w_go) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cnt_count_o = cnt_count_q;
    assign cnt_mode_o  = cnt_mode_q;
    assign cnt_rstn_o  = cnt_rstn_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
    assign state_o     = state_q;
    assign wrap_o      = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timer_ctrl.sv
// ============================================================================
// Module   : tb_bcd_timer_ctrl
// Brief    : Bench for bcd_timer_ctrl with a behavioural BCD counter and controller model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_timer_ctrl;

    localparam int TD = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       clear    = 1'b0;
    logic       dir_down = 1'b0;
    logic [7:0] target   = 8'h00;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       tc;
    logic       cnt_count;
    logic       cnt_mode;
    logic       cnt_rstn;
    logic       running;
    logic       done;
    logic [1:0] state;
    logic       wrap;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int wraps    = 0;
    int env_val  = 0;

    // Model: phase 0 idle, 1 run, 2 pause, 3 done; m_pre counts run cycles toward a tick.
    int m_phase = 0;
    int m_pre   = 0;
    bit m_cnt   = 1'b0;
    bit m_mode  = 1'b0;
    bit m_rstn  = 1'b0;
    bit m_wrap  = 1'b0;
    bit model_valid = 1'b0;

    bcd_timer_ctrl #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .stop_i      (stop),
        .clear_i     (clear),
        .dir_down_i  (dir_down),
        .target_i    (target),
        .q0_i        (q0),
        .q1_i        (q1),
        .tc_i        (tc),
        .cnt_count_o (cnt_count),
        .cnt_mode_o  (cnt_mode),
        .cnt_rstn_o  (cnt_rstn),
        .running_o   (running),
        .done_o      (done),
        .state_o     (state),
        .wrap_o      (wrap)
    );

    always #5 clk = ~clk;

    assign q0 = 4'(env_val % 10);
    assign q1 = 4'(env_val / 10);
    assign tc = cnt_mode ? (env_val == 0) : (env_val == 99);

    function automatic bit target_hit(input logic [7:0] t, input int v);
        int tens;
        int units;
        tens  = int'(t[7:4]);
        units = int'(t[3:0]);
        if (tens > 9 || units > 9) return 1'b0;
        return v == tens * 10 + units;
    endfunction

    always @(posedge clk) begin
        if (!cnt_rstn)
            env_val <= 0;
        else if (cnt_count)
            env_val <= cnt_mode ? (env_val + 99) % 100 : (env_val + 1) % 100;

        if (rst) begin
            model_valid <= 1'b1;
            m_phase <= 0;
            m_pre   <= 0;
            m_cnt   <= 1'b0;
            m_mode  <= 1'b0;
            m_rstn  <= 1'b0;
            m_wrap  <= 1'b0;
        end else begin
            m_rstn <= !clear;
            m_wrap <= m_cnt && tc;
            m_cnt  <= 1'b0;
            if (clear) begin
                m_phase <= 0;
                m_pre   <= 0;
            end else if (m_phase == 0) begin
                if (start && !stop) begin
                    m_phase <= 1;
                    m_mode  <= dir_down;
                    m_pre   <= 0;
                end
            end else if (m_phase == 1) begin
                if (stop) begin
                    m_phase <= 2;
                end else if (target_hit(target, env_val)) begin
                    m_phase <= 3;
                end else begin
                    m_pre <= (m_pre + 1) % TD;
                    m_cnt <= (m_pre + 1 == TD);
                end
            end else if (m_phase == 2) begin
                if (start && !stop) m_phase <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    int p0;
    int w0;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (model_valid) begin
                    chk("cnt_count", cnt_count, m_cnt);
                    chk("cnt_mode",  cnt_mode,  m_mode);
                    chk("cnt_rstn",  cnt_rstn,  m_rstn);
                    chk("running",   running,   m_phase == 1);
                    chk("done",      done,      m_phase == 3);
                    chk("state",     state,     m_phase);
                    chk("wrap",      wrap,      m_wrap);
                    if (cnt_count === 1'b1) pulses++;
                    if (wrap === 1'b1) wraps++;
                end
            end
        join_none

        cyc(3);
        rst = 1'b0;
        chk("rst_state", state, 2'b00);
        chk("rst_rstn", cnt_rstn, 1'b0);
        chk("rst_count", cnt_count, 1'b0);
        cyc(1);

        // 1: count up to 05
        pulse_clear();
        chk("t1_rstn_low", cnt_rstn, 1'b0);
        cyc(1);
        target = 8'h05;
        dir_down = 1'b0;
        p0 = pulses;
        pulse_start();
        chk("t1_run", state, 2'b01);
        cyc(40);
        chk("t1_pulses", pulses - p0, 5);
        chk("t1_state", state, 2'b11);
        chk("t1_done", done, 1'b1);
        chk("t1_value", env_val, 5);
        cyc(10);
        chk("t1_no_more", pulses - p0, 5);

        // 2: count down 00 -> 99 -> 98 -> 97 with one wrap
        pulse_clear();
        cyc(1);
        target = 8'h97;
        dir_down = 1'b1;
        p0 = pulses;
        w0 = wraps;
        pulse_start();
        cyc(30);
        chk("t2_pulses", pulses - p0, 3);
        chk("t2_wraps", wraps - w0, 1);
        chk("t2_mode", cnt_mode, 1'b1);
        chk("t2_value", env_val, 97);
        chk("t2_state", state, 2'b11);

        // 3: pause with prescaler at 2, then resume
        pulse_clear();
        cyc(1);
        target = 8'hFF;
        dir_down = 1'b0;
        pulse_start();
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t3_pause", state, 2'b10);
        p0 = pulses;
        cyc(20);
        chk("t3_no_pulse", pulses - p0, 0);
        chk("t3_still_pause", state, 2'b10);
        pulse_start();
        chk("t3_resume", state, 2'b01);
        chk("t3_c0", cnt_count, 1'b0);
        cyc(1);
        chk("t3_c1", cnt_count, 1'b0);
        cyc(1);
        chk("t3_first_tick", cnt_count, 1'b1);
        cyc(3);
        chk("t3_gap", cnt_count, 1'b0);
        cyc(1);
        chk("t3_second_tick", cnt_count, 1'b1);

        // 4: clear mid-run
        cyc(3);
        chk("t4_nonzero", env_val == 2, 1'b1);
        pulse_clear();
        chk("t4_rstn_low", cnt_rstn, 1'b0);
        chk("t4_idle", state, 2'b00);
        chk("t4_not_running", running, 1'b0);
        cyc(1);
        chk("t4_value", env_val, 0);
        chk("t4_rstn_high", cnt_rstn, 1'b1);
        p0 = pulses;
        cyc(10);
        chk("t4_no_pulse", pulses - p0, 0);

        // 5: start and stop together in idle
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        chk("t5_idle", state, 2'b00);
        p0 = pulses;
        cyc(10);
        chk("t5_no_pulse", pulses - p0, 0);
        chk("t5_idle2", state, 2'b00);

        // 6: immediate match at 00
        target = 8'h00;
        dir_down = 1'b1;
        p0 = pulses;
        pulse_start();
        chk("t6_run", state, 2'b01);
        cyc(1);
        chk("t6_done", state, 2'b11);
        chk("t6_mode", cnt_mode, 1'b1);
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("t6_held", state, 2'b11);
        chk("t6_no_pulse", pulses - p0, 0);
        pulse_clear();
        chk("t6_cleared", state, 2'b00);

        rst = 1'b1;
        cyc(1);
        chk("end_rst_state", state, 2'b00);
        chk("end_rst_mode", cnt_mode, 1'b0);
        chk("end_rst_rstn", cnt_rstn, 1'b0);
        rst = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
